// File: rtl/seg_scan_decoder.sv
// Decodes a scanned, multiplexed active-low 7-segment display back into four hex nibbles.
// Each (anode, segment) sample must be stable before it is captured. Complete frames are held until acknowledged.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  input  logic        frame_ack,
  output logic [15:0] digit_val,
  output logic [3:0]  digit_ok,
  output logic        frame_valid,
  output logic        err,
  output logic        overrun
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t      state_reg;
  logic [10:0] sample_reg;
  logic [3:0]  count_reg;
  logic [3:0]  mask_reg;

  logic [10:0] sample_now;
  logic        same;
  logic        capture;
  logic        cap_nb;
  logic [3:0]  an_low;
  logic        one_hot;
  logic        process;
  logic        write_en;
  logic [3:0]  nib;
  logic        legal;

  assign sample_now = {an_in, seg_in};
  assign same       = (sample_now == sample_reg);
  // Fires only on the edge where the count reaches the threshold. The count saturates, so a held value fires once.
  assign capture    = same && (count_reg == STABLE_N - 4'd1);
  assign cap_nb     = capture && (an_in != 4'b1111);
  assign an_low     = ~an_in;
  assign one_hot    = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
  // In HOLD, an ack on the same edge lets the capture go through as a normal COLLECT capture.
  assign process    = cap_nb && ((state_reg == COLLECT) || frame_ack);
  assign write_en   = process && one_hot;

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (seg_in)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0001100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= 11'h7FF;
      count_reg  <= 4'd0;
    end else begin
      sample_reg <= sample_now;
      if (!same)
        count_reg <= 4'd1;
      else if (count_reg != STABLE_N)
        count_reg <= count_reg + 4'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    always_ff @(posedge clk) begin
      if (rst) begin
        digit_val[gi*4 +: 4] <= 4'h0;
        digit_ok[gi]         <= 1'b0;
      end else if (write_en && an_low[gi]) begin
        digit_val[gi*4 +: 4] <= legal ? nib : 4'h0;
        digit_ok[gi]         <= legal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= COLLECT;
      mask_reg    <= 4'd0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= process && (!one_hot || !legal);
      if (state_reg == HOLD) begin
        if (frame_ack) begin
          frame_valid <= 1'b0;
          overrun     <= 1'b0;
          state_reg   <= COLLECT;
        end else if (cap_nb) begin
          overrun <= 1'b1;
        end
      end
      // Later assignments win, so a capture that completes a frame on the ack edge re-enters HOLD.
      if (write_en) begin
        if ((mask_reg | an_low) == 4'hF) begin
          frame_valid <= 1'b1;
          mask_reg    <= 4'd0;
          state_reg   <= HOLD;
        end else begin
          mask_reg <= mask_reg | an_low;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder. It runs directed scenarios first and then random scan traffic.
// The outputs are compared every cycle against a reference model built from the history of samples.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        frame_ack;
  logic [15:0] digit_val;
  logic [3:0]  digit_ok;
  logic        frame_valid;
  logic        err;
  logic        overrun;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .frame_ack(frame_ack),
    .digit_val(digit_val), .digit_ok(digit_ok), .frame_valid(frame_valid),
    .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0]  seg_tab [16];
  logic [10:0] hist [$];
  logic [3:0]  m_dig [4];
  logic        m_ok [4];
  logic [3:0]  m_mask;
  logic        m_hold, m_fv, m_ov, m_err;
  int          m_caps;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_val();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  function automatic logic [3:0] m_okv();
    return {m_ok[3], m_ok[2], m_ok[1], m_ok[0]};
  endfunction

  // Reference model for one clock edge, written in terms of the observable rules.
  task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic k, input logic r);
    logic cap;
    int   n, idx, hit;
    logic [10:0] cur;
    m_err = 1'b0;
    if (r) begin
      hist.delete();
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'h0; m_ok[i] = 1'b0; end
      m_mask = 4'h0; m_hold = 1'b0; m_fv = 1'b0; m_ov = 1'b0;
      return;
    end
    cur = {a, s};
    hist.push_back(cur);
    if (hist.size() > S + 1) void'(hist.pop_front());
    n = hist.size();
    // Capture when the newest S samples match and the sample before them (if any) differs.
    cap = (n >= S);
    for (int i = n - S; cap && i < n; i++) if (hist[i] != cur) cap = 1'b0;
    if (cap && n > S && hist[n-S-1] == cur) cap = 1'b0;
    if (m_hold && k) begin m_hold = 1'b0; m_fv = 1'b0; m_ov = 1'b0; end
    if (!cap || a == 4'hF) return;
    if (m_hold) begin m_ov = 1'b1; return; end
    m_caps++;
    if ($countones(~a) > 1) begin m_err = 1'b1; return; end
    idx = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
    hit = -1;
    for (int v = 0; v < 16; v++) if (seg_tab[v] == s) hit = v;
    if (hit >= 0) begin m_dig[idx] = 4'(hit); m_ok[idx] = 1'b1; end
    else begin m_dig[idx] = 4'h0; m_ok[idx] = 1'b0; m_err = 1'b1; end
    m_mask[idx] = 1'b1;
    if (m_mask == 4'hF) begin m_fv = 1'b1; m_mask = 4'h0; m_hold = 1'b1; end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic k, input logic r);
    an_in = a; seg_in = s; frame_ack = k; rst = r;
    @(posedge clk);
    model_edge(a, s, k, r);
    #1;
    chk("digit_val", digit_val, m_val());
    chk("digit_ok", {12'd0, digit_ok}, {12'd0, m_okv()});
    chk("frame_valid", {15'd0, frame_valid}, {15'd0, m_fv});
    chk("err", {15'd0, err}, {15'd0, m_err});
    chk("overrun", {15'd0, overrun}, {15'd0, m_ov});
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s, 1'b0, 1'b0);
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    m_caps = 0;
    an_in = 4'hF; seg_in = 7'h7F; frame_ack = 1'b0; rst = 1'b1;

    step(4'hF, 7'h7F, 1'b0, 1'b1);
    step(4'hF, 7'h7F, 1'b0, 1'b1);
    chk("reset_val", digit_val, 16'h0000);

    // Basic frame B A 3 2
    hold(4'b1110, 7'b0010010, 4);
    hold(4'b1101, 7'b0000110, 4);
    hold(4'b1011, 7'b0001000, 4);
    hold(4'b0111, 7'b1100000, 4);
    chk("frame_val", digit_val, 16'hBA32);
    chk("frame_ok", {12'd0, digit_ok}, 16'h000F);
    chk("frame_fv", {15'd0, frame_valid}, 16'h0001);

    // Overrun while a frame is held, then acknowledge
    hold(4'b1110, 7'b1001111, 4);
    chk("ovr_set", {15'd0, overrun}, 16'h0001);
    chk("ovr_frozen", digit_val, 16'hBA32);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    chk("ack_fv", {15'd0, frame_valid}, 16'h0000);
    chk("ack_ovr", {15'd0, overrun}, 16'h0000);

    // Stability: three samples are too few, and a long hold captures only once
    hold(4'b1110, 7'b1001111, 3);
    hold(4'b1101, 7'b0000001, 1);
    m_caps = 0;
    hold(4'b1110, 7'b1001111, 20);
    chk("stable_once", 16'(m_caps), 16'd1);
    chk("stable_dig0", {12'd0, digit_val[3:0]}, 16'h0001);

    // Illegal captures
    hold(4'b1100, 7'b0000001, 5);
    hold(4'b1110, 7'b1111111, 5);
    chk("illegal_ok0", {15'd0, digit_ok[0]}, 16'h0000);
    chk("illegal_nib", {12'd0, digit_val[3:0]}, 16'h0000);

    // Ack arriving on the same edge as a capture
    hold(4'b1101, 7'b0000110, 4);
    hold(4'b1011, 7'b0001000, 4);
    hold(4'b0111, 7'b1100000, 4);
    hold(4'b1110, 7'b0000000, 3);
    step(4'b1110, 7'b0000000, 1'b1, 1'b0);
    chk("ackcap_ovr", {15'd0, overrun}, 16'h0000);
    chk("ackcap_dig", {12'd0, digit_val[3:0]}, 16'h0008);
    chk("ackcap_fv", {15'd0, frame_valid}, 16'h0000);

    // Reset in HOLD with a count pending
    hold(4'b1101, 7'b0000110, 4);
    hold(4'b1011, 7'b0001000, 4);
    hold(4'b0111, 7'b1100000, 4);
    hold(4'b1101, 7'b0010010, 2);
    step(4'b1101, 7'b0010010, 1'b0, 1'b1);
    chk("rst_fv", {15'd0, frame_valid}, 16'h0000);
    hold(4'b1101, 7'b0010010, 3);
    chk("rst_nocap", {12'd0, digit_ok}, 16'h0000);
    hold(4'b1101, 7'b0010010, 1);
    chk("rst_cap", {12'd0, digit_ok}, 16'h0002);

    // Random scan traffic
    for (int it = 0; it < 150; it++) begin
      logic [3:0] a;
      logic [6:0] s;
      int len;
      case ($urandom_range(0, 9))
        0:       a = 4'hF;
        1:       a = 4'(~(1 << $urandom_range(0, 3)) & ~(1 << $urandom_range(0, 3)));
        default: a = 4'(~(1 << $urandom_range(0, 3)));
      endcase
      s = ($urandom_range(0, 5) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++)
        step(a, s, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 80) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
